// File: rtl/ysyx_22050854_divider_v1.sv
// ysyx_22050854_divider_v1: iterative restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// One quotient bit per BUSY cycle; divide-by-zero and signed overflow bypass iteration.
module ysyx_22050854_divider_v1 #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            div_valid,
   input  logic            flush,
   input  logic            divw,
   input  logic            div_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            div_ready,
   output logic            div_doing,
   output logic            out_valid,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   localparam int HW = XLEN / 2;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t          state_q;
   logic [XLEN-1:0] rem_q, quo_q, b_q, quotient_q, remainder_q;
   logic [6:0]      cnt_q;
   logic            neg_q_q, neg_r_q, divw_q, out_valid_q;
   logic [XLEN-1:0] a_eff, b_eff, a_abs, b_abs, min_val, rem_d, quo_d;
   logic [XLEN-1:0] q_fix, r_fix, q_res, r_res;
   logic [XLEN:0]   shifted;
   logic            sa, sb, div_zero, ovf, special, accept, ge, last, fin;
   always_comb begin
      a_eff    = divw ? {{HW{div_signed & dividend[HW-1]}}, dividend[HW-1:0]} : dividend;
      b_eff    = divw ? {{HW{div_signed & divisor[HW-1]}}, divisor[HW-1:0]} : divisor;
      sa       = div_signed & a_eff[XLEN-1];
      sb       = div_signed & b_eff[XLEN-1];
      a_abs    = sa ? -a_eff : a_eff;
      b_abs    = sb ? -b_eff : b_eff;
      min_val  = divw ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = b_eff == '0;
      ovf      = div_signed & (a_eff == min_val) & (b_eff == '1);
      special  = div_zero | ovf;
      accept   = (state_q == IDLE) & div_valid & ~flush;
      // partial remainder is XLEN+1 bits wide only for the compare/subtract
      shifted  = {rem_q, quo_q[XLEN-1]};
      ge       = shifted >= {1'b0, b_q};
      rem_d    = ge ? shifted[XLEN-1:0] - b_q : shifted[XLEN-1:0];
      quo_d    = {quo_q[XLEN-2:0], ge};
      last     = cnt_q == (divw_q ? 7'(HW - 1) : 7'(XLEN - 1));
      q_fix    = neg_q_q ? -quo_q : quo_q;
      r_fix    = neg_r_q ? -rem_q : rem_q;
      q_res    = divw_q ? {{HW{q_fix[HW-1]}}, q_fix[HW-1:0]} : q_fix;
      r_res    = divw_q ? {{HW{r_fix[HW-1]}}, r_fix[HW-1:0]} : r_fix;
      fin      = (state_q == DONE) & ~flush;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         divw_q      <= 1'b0;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         out_valid_q <= fin;
         quotient_q  <= fin ? q_res : '0;
         remainder_q <= fin ? r_res : '0;
         case (state_q)
            IDLE: if (accept) begin
               state_q <= special ? DONE : BUSY;
               cnt_q   <= '0;
               divw_q  <= divw;
               neg_q_q <= ~special & (sa ^ sb);
               neg_r_q <= ~special & sa;
               b_q     <= b_abs;
               rem_q   <= div_zero ? a_eff : '0;
               // W ops park the 32-bit dividend in the top half so the first shift pulls its MSB
               quo_q   <= div_zero ? '1 : ovf ? min_val : divw ? {a_abs[HW-1:0], {HW{1'b0}}} : a_abs;
            end
            BUSY: if (flush) begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end else begin
               rem_q   <= rem_d;
               quo_q   <= quo_d;
               cnt_q   <= last ? cnt_q : cnt_q + 7'd1;
               state_q <= last ? DONE : BUSY;
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign div_ready = state_q == IDLE;
   assign div_doing = state_q == BUSY;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
endmodule

// File: tb/tb_ysyx_22050854_divider_v1.sv
// tb_ysyx_22050854_divider_v1: scoreboard bench for the iterative divider.
module tb_ysyx_22050854_divider_v1;
   logic        clock = 0, reset = 1, div_valid = 0, flush = 0, divw = 0, div_signed = 0;
   logic [63:0] dividend = 0, divisor = 0;
   logic        div_ready, div_doing, out_valid;
   logic [63:0] quotient, remainder;
   typedef struct {logic [63:0] q; logic [63:0] r; int lat;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;

   ysyx_22050854_divider_v1 #(.XLEN(64)) dut (
      .clock(clock), .reset(reset), .div_valid(div_valid), .flush(flush), .divw(divw),
      .div_signed(div_signed), .dividend(dividend), .divisor(divisor), .div_ready(div_ready),
      .div_doing(div_doing), .out_valid(out_valid), .quotient(quotient), .remainder(remainder));

   always #5 clock = ~clock;

   function automatic void model(input logic w, s, input logic [63:0] a, b,
                                 output logic [63:0] q, r, output bit sp);
      logic [31:0] a32, b32, q32, r32;
      a32 = a[31:0];
      b32 = b[31:0];
      if (w) begin
         sp = (b32 == 0) || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
         if (b32 == 0) begin q32 = '1; r32 = a32; end
         else if (sp) begin q32 = a32; r32 = 0; end
         else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
         else begin q32 = a32 / b32; r32 = a32 % b32; end
         q = {{32{q32[31]}}, q32};
         r = {{32{r32[31]}}, r32};
      end else begin
         sp = (b == 0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
         if (b == 0) begin q = '1; r = a; end
         else if (sp) begin q = a; r = 0; end
         else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
         else begin q = a / b; r = a % b; end
      end
   endfunction

   // drives one request; returns at the negedge right after the accept edge
   task automatic start_op(input logic w, s, input logic [63:0] a, b, input bit push);
      exp_t e;
      bit sp;
      @(negedge clock);
      divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1;
      if (push) begin
         model(w, s, a, b, e.q, e.r, sp);
         e.lat = sp ? 1 : (w ? 33 : 65);
         sb.push_back(e);
      end
      @(negedge clock);
      div_valid = 0; dividend = ~a; divisor = ~b; divw = ~w; div_signed = ~s;
   endtask

   task automatic wait_out(output logic [63:0] q, r, output int lat, doing, output bit ok, gone);
      lat = 0; doing = 0; ok = 0; q = 'x; r = 'x;
      while (lat < 200 && !ok) begin
         if (out_valid) begin ok = 1; q = quotient; r = remainder; end
         else begin doing += int'(div_doing); @(negedge clock); lat++; end
      end
      @(negedge clock);
      gone = !out_valid && quotient == 0 && remainder == 0;
   endtask

   task automatic quiet(input int n, output int seen);
      seen = 0;
      repeat (n) begin @(negedge clock); seen += int'(out_valid); end
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (3) @(negedge clock);
      checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", div_ready); end
      checks++; if (div_doing !== 1'b0) begin errors++; $display("FAIL reset_doing got %b want 0", div_doing); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (quotient !== 64'h0) begin errors++; $display("FAIL reset_q got %h want 0", quotient); end
      checks++; if (remainder !== 64'h0) begin errors++; $display("FAIL reset_r got %h want 0", remainder); end
      reset = 0;
   endtask

   task automatic test_unsigned64;
      logic [63:0] q, r; int lat, doing; bit ok, gone; exp_t e;
      start_op(0, 0, 64'd100, 64'd7, 1);
      wait_out(q, r, lat, doing, ok, gone);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL u64_timeout got none want out_valid"); end
      checks++; if (q !== 64'd14 || q !== e.q) begin errors++; $display("FAIL u64_q got %h want %h", q, e.q); end
      checks++; if (r !== 64'd2 || r !== e.r) begin errors++; $display("FAIL u64_r got %h want %h", r, e.r); end
      checks++; if (lat !== 65) begin errors++; $display("FAIL u64_latency got %0d want 65", lat); end
      checks++; if (doing !== 64) begin errors++; $display("FAIL u64_doing got %0d want 64", doing); end
      checks++; if (!gone) begin errors++; $display("FAIL u64_pulse got wide/nonzero want 1-cycle"); end
   endtask

   task automatic test_signed64;
      logic [63:0] q, r; int lat, doing; bit ok, gone; exp_t e;
      logic [63:0] a[3] = '{-64'sd7, 64'sd7, 64'h8000_0000_0000_0000};
      logic [63:0] b[3] = '{64'sd2, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [63:0] wq[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0000};
      logic [63:0] wr[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
      int wl[3] = '{65, 65, 1};
      for (int i = 0; i < 3; i++) begin
         start_op(0, 1, a[i], b[i], 1);
         wait_out(q, r, lat, doing, ok, gone);
         e = sb.pop_front();
         checks++; if (q !== wq[i] || q !== e.q) begin errors++; $display("FAIL s64_q[%0d] got %h want %h", i, q, wq[i]); end
         checks++; if (r !== wr[i] || r !== e.r) begin errors++; $display("FAIL s64_r[%0d] got %h want %h", i, r, wr[i]); end
         checks++; if (lat !== wl[i]) begin errors++; $display("FAIL s64_lat[%0d] got %0d want %0d", i, lat, wl[i]); end
      end
   endtask

   task automatic test_divw_overflow;
      logic [63:0] q, r; int lat, doing; bit ok, gone; exp_t e;
      start_op(1, 1, 64'hDEAD_BEEF_8000_0000, 64'h1234_5678_FFFF_FFFF, 1);
      wait_out(q, r, lat, doing, ok, gone);
      e = sb.pop_front();
      checks++; if (q !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL ovfw_q got %h want ffffffff80000000", q); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL ovfw_r got %h want %h", r, e.r); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL ovfw_lat got %0d want 1", lat); end
      checks++; if (doing !== 0) begin errors++; $display("FAIL ovfw_doing got %0d want 0", doing); end
   endtask

   task automatic test_div_zero;
      logic [63:0] q, r; int lat, doing; bit ok, gone; exp_t e;
      start_op(0, 0, 64'd5, 64'd0, 1);
      wait_out(q, r, lat, doing, ok, gone);
      e = sb.pop_front();
      checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dz64_q got %h want all ones", q); end
      checks++; if (r !== 64'd5 || r !== e.r) begin errors++; $display("FAIL dz64_r got %h want 5", r); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL dz64_lat got %0d want 1", lat); end
      start_op(1, 0, 64'h8000_0001, 64'h1_0000_0000, 1);
      wait_out(q, r, lat, doing, ok, gone);
      e = sb.pop_front();
      checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dzw_q got %h want all ones", q); end
      checks++; if (r !== 64'hFFFF_FFFF_8000_0001 || r !== e.r) begin errors++; $display("FAIL dzw_r got %h want ffffffff80000001", r); end
      checks++; if (!gone) begin errors++; $display("FAIL dzw_pulse got wide/nonzero want 1-cycle"); end
   endtask

   task automatic test_flush_back_to_back;
      logic [63:0] q, r; int lat, doing, seen; bit ok, gone; exp_t e;
      start_op(0, 0, 64'hFFFF_0000_1234_5678, 64'd3, 0);
      repeat (10) @(negedge clock);
      flush = 1;
      @(negedge clock);
      flush = 0;
      checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", div_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
      start_op(1, 0, 64'hFFFF_FFFF, 64'd3, 1);
      wait_out(q, r, lat, doing, ok, gone);
      e = sb.pop_front();
      checks++; if (q !== 64'h5555_5555 || q !== e.q) begin errors++; $display("FAIL divuw_q got %h want 55555555", q); end
      checks++; if (r !== 64'd0) begin errors++; $display("FAIL divuw_r got %h want 0", r); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL divuw_lat got %0d want 33", lat); end
      checks++; if (doing !== 32) begin errors++; $display("FAIL divuw_doing got %0d want 32", doing); end
      quiet(70, seen);
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_stray got %0d pulses want 0", seen); end
   endtask

   task automatic test_busy_ignore;
      logic [63:0] q, r; int lat, doing, seen; bit ok, gone; exp_t e;
      start_op(0, 1, -64'sd1000, 64'sd33, 1);
      repeat (5) @(negedge clock);
      checks++; if (div_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", div_ready); end
      div_valid = 1; divw = 0; div_signed = 0; dividend = 64'd9; divisor = 64'd0;
      @(negedge clock);
      div_valid = 0;
      wait_out(q, r, lat, doing, ok, gone);
      e = sb.pop_front();
      checks++; if (q !== e.q) begin errors++; $display("FAIL busy_q got %h want %h", q, e.q); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL busy_r got %h want %h", r, e.r); end
      quiet(70, seen);
      checks++; if (seen !== 0) begin errors++; $display("FAIL busy_stray got %0d pulses want 0", seen); end
   endtask

   task automatic test_reset_mid_busy;
      logic [63:0] q, r; int lat, doing, seen; bit ok, gone; exp_t e;
      start_op(0, 0, 64'd12345, 64'd6, 0);
      repeat (20) @(negedge clock);
      reset = 1;
      @(negedge clock);
      checks++; if ({div_ready, div_doing, out_valid} !== 3'b100) begin errors++; $display("FAIL rstbusy_flags got %b want 100", {div_ready, div_doing, out_valid}); end
      checks++; if (quotient !== 0 || remainder !== 0) begin errors++; $display("FAIL rstbusy_data got %h/%h want 0/0", quotient, remainder); end
      reset = 0;
      quiet(70, seen);
      checks++; if (seen !== 0) begin errors++; $display("FAIL rstbusy_stray got %0d pulses want 0", seen); end
      start_op(0, 0, 64'd12345, 64'd6, 1);
      wait_out(q, r, lat, doing, ok, gone);
      e = sb.pop_front();
      checks++; if (q !== 64'd2057 || r !== 64'd3) begin errors++; $display("FAIL rstbusy_next got %h/%h want 809/3", q, r); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL rstbusy_lat got %0d want %0d", lat, e.lat); end
   endtask

   task automatic test_random;
      logic [63:0] q, r, a, b; int lat, doing; bit ok, gone; exp_t e; logic w, s;
      for (int i = 0; i < 10; i++) begin
         w = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom} >> $urandom_range(0, 62);
         start_op(w, s, a, b, 1);
         wait_out(q, r, lat, doing, ok, gone);
         e = sb.pop_front();
         checks++; if (q !== e.q || r !== e.r) begin errors++; $display("FAIL rnd[%0d] w%0d s%0d %h/%h got %h,%h want %h,%h", i, w, s, a, b, q, r, e.q, e.r); end
         checks++; if (lat !== e.lat) begin errors++; $display("FAIL rnd_lat[%0d] got %0d want %0d", i, lat, e.lat); end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned64();
      test_signed64();
      test_divw_overflow();
      test_div_zero();
      test_flush_back_to_back();
      test_busy_ignore();
      test_reset_mid_busy();
      test_random();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
